// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with built-in EX/MEM output registers.
// Single-cycle ALU ops complete in one cycle; MULT/MULTU/DIV/DIVU run
// iteratively (32 steps) into internal HI/LO registers while stall is high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            ID/EX holds a real instruction (0 = bubble)
//   RD1_in, RD2_in      rs / rt operands (RD2_in is also store data)
//   imm_ext_in          sign-extended immediate, [10:6] = shift amount
//   rt_in, rd_in        destination candidates
//   ex_op               operation select
//   alu_src, reg_dst    operand B / destination selects
//   reg_write_in, mem_read_in, mem_write_in   control passed to MEM/WB
//   *_out               registered EX/MEM results and control
//   stall               combinational hold request for PC, IF/ID, ID/EX
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready; ALU ops retire every cycle, mul/div start here
// BUSY  | one multiply/divide iteration per cycle, 32 iterations
// DONE  | mul/div still on inputs; retire it as a bubble, back to IDLE
module ex_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] RD1_in,
   input  logic [DATA_W-1:0] RD2_in,
   input  logic [DATA_W-1:0] imm_ext_in,
   input  logic [4:0]        rt_in,
   input  logic [4:0]        rd_in,
   input  logic [4:0]        ex_op,
   input  logic              alu_src,
   input  logic              reg_dst,
   input  logic              reg_write_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] store_data_out,
   output logic [4:0]        write_reg_out,
   output logic              reg_write_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic              valid_out,
   output logic              stall
);

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4,  OP_NOR = 5'd5,  OP_SLT = 5'd6,  OP_SLTU = 5'd7;
   localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL = 5'd9,  OP_SRA = 5'd10;
   localparam logic [4:0] OP_MULT = 5'd11, OP_MULTU = 5'd12, OP_DIV = 5'd13, OP_DIVU = 5'd14;
   localparam logic [4:0] OP_MFHI = 5'd15, OP_MFLO = 5'd16, OP_LUI = 5'd17;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q;
   logic [63:0] work_q;       // mul: {acc, multiplier}; div: {remainder, quotient}
   logic [31:0] opnd_q;       // mul: multiplicand magnitude; div: divisor magnitude
   logic        is_div_q, neg_q, neg_rem_q, div_zero_q;
   logic [31:0] hi_q, lo_q;

   logic [31:0] op_a, op_b, alu_res, mag_a, mag_b;
   logic [4:0]  shamt;
   logic        is_muldiv, start, signed_op, sign_a, sign_b, retire;
   logic [32:0] mul_sum, div_diff;
   logic [63:0] mul_next, div_next, work_step, prod_fix;
   logic [31:0] quot_fix, rem_fix;

   assign op_a  = RD1_in;
   assign op_b  = alu_src ? imm_ext_in : RD2_in;
   assign shamt = imm_ext_in[10:6];

   assign is_muldiv = (ex_op >= OP_MULT) && (ex_op <= OP_DIVU);
   assign start     = (state_q == S_IDLE) && in_valid && is_muldiv;
   assign stall     = start || (state_q == S_BUSY);
   assign retire    = in_valid && (state_q == S_IDLE) && !is_muldiv;

   assign signed_op = (ex_op == OP_MULT) || (ex_op == OP_DIV);
   assign sign_a    = signed_op && op_a[31];
   assign sign_b    = signed_op && op_b[31];
   assign mag_a     = sign_a ? -op_a : op_a;
   assign mag_b     = sign_b ? -op_b : op_b;

   // Shift-add multiply step: add multiplicand into upper half when the
   // current multiplier LSB is set, then shift the whole pair right.
   assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next = {mul_sum, work_q[31:1]};

   // Restoring divide step: the shifted partial remainder fits in 33 bits
   // and stays below 2*divisor, so diff[32] is a true borrow flag.
   assign div_diff = work_q[63:31] - {1'b0, opnd_q};
   assign div_next = div_diff[32] ? {work_q[62:0], 1'b0}
                                  : {div_diff[31:0], work_q[30:0], 1'b1};

   assign work_step = is_div_q ? div_next : mul_next;
   assign prod_fix  = neg_q ? -work_step : work_step;
   // Divide by zero: quotient forced to all ones; remainder holds |A| and
   // the sign fix restores the original A.
   assign quot_fix  = div_zero_q ? 32'hFFFF_FFFF
                                 : (neg_q ? -work_step[31:0] : work_step[31:0]);
   assign rem_fix   = neg_rem_q ? -work_step[63:32] : work_step[63:32];

   always_comb begin
      alu_res = 32'd0;
      case (ex_op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         OP_SLTU: alu_res = {31'd0, op_a < op_b};
         OP_SLL:  alu_res = op_b << shamt;
         OP_SRL:  alu_res = op_b >> shamt;
         OP_SRA:  alu_res = $signed(op_b) >>> shamt;
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         OP_LUI:  alu_res = {op_b[15:0], 16'h0000};
         default: alu_res = 32'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BUSY;
         S_BUSY:  if (cnt_q == 6'd31) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 6'd0;
         work_q     <= 64'd0;
         opnd_q     <= 32'd0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         state_q <= state_d;
         if (start) begin
            cnt_q      <= 6'd0;
            is_div_q   <= (ex_op == OP_DIV) || (ex_op == OP_DIVU);
            neg_q      <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= (op_b == 32'd0);
            if ((ex_op == OP_DIV) || (ex_op == OP_DIVU)) begin
               work_q <= {32'd0, mag_a};
               opnd_q <= mag_b;
            end else begin
               work_q <= {32'd0, mag_b};
               opnd_q <= mag_a;
            end
         end else if (state_q == S_BUSY) begin
            work_q <= work_step;
            cnt_q  <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quot_fix;
               end else begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result_out <= '0;
         store_data_out <= '0;
         write_reg_out  <= 5'd0;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         valid_out      <= 1'b0;
      end else begin
         alu_result_out <= alu_res;
         store_data_out <= RD2_in;
         write_reg_out  <= reg_dst ? rd_in : rt_in;
         reg_write_out  <= retire && reg_write_in;
         mem_read_out   <= retire && mem_read_in;
         mem_write_out  <= retire && mem_write_in;
         valid_out      <= retire;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, bubbles, iterative mul/div
// with HI/LO readback, divide corner cases and reset during a divide.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] RD1_in, RD2_in, imm_ext_in;
   logic [4:0]  rt_in, rd_in, ex_op;
   logic        alu_src, reg_dst, reg_write_in, mem_read_in, mem_write_in;
   logic [31:0] alu_result_out, store_data_out;
   logic [4:0]  write_reg_out;
   logic        reg_write_out, mem_read_out, mem_write_out, valid_out, stall;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ex_stage #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .RD1_in(RD1_in), .RD2_in(RD2_in), .imm_ext_in(imm_ext_in),
      .rt_in(rt_in), .rd_in(rd_in), .ex_op(ex_op),
      .alu_src(alu_src), .reg_dst(reg_dst),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .write_reg_out(write_reg_out), .reg_write_out(reg_write_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .valid_out(valid_out), .stall(stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid     = 1'b1;
      ex_op        = op;
      RD1_in       = a;
      RD2_in       = b;
      imm_ext_in   = 32'd0;
      alu_src      = 1'b0;
      reg_dst      = 1'b1;
      rt_in        = 5'd0;
      rd_in        = 5'd3;
      reg_write_in = 1'b1;
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
   endtask

   // Presents a mul/div and walks cycles 0..33; returns at the start of cycle 34.
   task automatic run_muldiv(input string tag, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b);
      int stalls;
      int pulses;
      stalls = 0;
      pulses = 0;
      issue(op, a, b);
      for (int i = 0; i < 34; i++) begin
         #1;
         if (stall) stalls++;
         tick();
         if (reg_write_out || valid_out) pulses++;
      end
      chk({tag, " stall cycles"}, stalls, 32'd33);
      chk({tag, " output pulses"}, pulses, 32'd0);
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(5'd15, 32'd0, 32'd0);
      tick();
      chk({tag, " HI"}, alu_result_out, exp_hi);
      issue(5'd16, 32'd0, 32'd0);
      tick();
      chk({tag, " LO"}, alu_result_out, exp_lo);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with arbitrary live inputs
      rst = 1'b1;
      issue(5'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      mem_read_in  = 1'b1;
      mem_write_in = 1'b1;
      tick();
      tick();
      chk("rst alu_result", alu_result_out, 32'd0);
      chk("rst store_data", store_data_out, 32'd0);
      chk("rst write_reg", {27'd0, write_reg_out}, 32'd0);
      chk("rst ctrl", {28'd0, reg_write_out, mem_read_out, mem_write_out, valid_out}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst stall", {31'd0, stall}, 32'd0);
      read_hilo("rst", 32'd0, 32'd0);

      // ADD immediate
      issue(5'd0, 32'd5, 32'd0);
      imm_ext_in = 32'hFFFF_FFFF;
      alu_src    = 1'b1;
      reg_dst    = 1'b0;
      rt_in      = 5'd9;
      rd_in      = 5'd17;
      tick();
      chk("addi result", alu_result_out, 32'd4);
      chk("addi write_reg", {27'd0, write_reg_out}, 32'd9);
      chk("addi reg_write", {31'd0, reg_write_out}, 32'd1);
      chk("addi valid", {31'd0, valid_out}, 32'd1);

      issue(5'd6, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("slt", alu_result_out, 32'd1);
      issue(5'd7, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("sltu", alu_result_out, 32'd0);
      chk("sltu write_reg rd", {27'd0, write_reg_out}, 32'd3);

      issue(5'd10, 32'd0, 32'h8000_0000);
      imm_ext_in = 32'h0000_0100;
      tick();
      chk("sra", alu_result_out, 32'hF800_0000);
      issue(5'd9, 32'd0, 32'h8000_0000);
      imm_ext_in = 32'h0000_0100;
      tick();
      chk("srl", alu_result_out, 32'h0800_0000);
      issue(5'd8, 32'd0, 32'h8000_0001);
      imm_ext_in = 32'h0000_0100;
      tick();
      chk("sll", alu_result_out, 32'h0000_0010);

      issue(5'd17, 32'd0, 32'd0);
      imm_ext_in = 32'h0000_1234;
      alu_src    = 1'b1;
      tick();
      chk("lui", alu_result_out, 32'h1234_0000);

      issue(5'd1, 32'd3, 32'd5);
      tick();
      chk("sub", alu_result_out, 32'hFFFF_FFFE);
      issue(5'd5, 32'h0F0F_0000, 32'h0000_00F0);
      tick();
      chk("nor", alu_result_out, 32'hF0F0_FF0F);

      // Store-style op: data and mem_write pass through, no reg_write
      issue(5'd0, 32'd10, 32'hDEAD_BEEF);
      reg_write_in = 1'b0;
      mem_write_in = 1'b1;
      tick();
      chk("store addr", alu_result_out, 32'hDEAD_BEF9);
      chk("store data", store_data_out, 32'hDEAD_BEEF);
      chk("store ctrl", {29'd0, reg_write_out, mem_write_out, valid_out}, 32'b011);

      // Bubble: control must be squashed
      issue(5'd0, 32'd1, 32'd1);
      in_valid     = 1'b0;
      mem_read_in  = 1'b1;
      mem_write_in = 1'b1;
      tick();
      chk("bubble ctrl", {28'd0, reg_write_out, mem_read_out, mem_write_out, valid_out}, 32'd0);

      // Multiply / divide
      run_muldiv("mult", 5'd11, 32'hFFFF_FFFD, 32'd7);
      read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      run_muldiv("div", 5'd13, 32'hFFFF_FFF9, 32'd2);
      read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_muldiv("divu0", 5'd14, 32'd7, 32'd0);
      read_hilo("divu0", 32'd7, 32'hFFFF_FFFF);

      run_muldiv("divovf", 5'd13, 32'h8000_0000, 32'hFFFF_FFFF);
      read_hilo("divovf", 32'd0, 32'h8000_0000);

      // Back-to-back: MFHI presented right in cycle 34
      run_muldiv("multu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_hilo("multu", 32'hFFFF_FFFE, 32'd1);

      // Reset in cycle 10 of a DIV
      issue(5'd13, 32'd100, 32'd7);
      for (int i = 0; i < 10; i++) tick();
      #1;
      chk("div busy stall", {31'd0, stall}, 32'd1);
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      issue(5'd0, 32'd2, 32'd3);
      #1;
      chk("post-rst stall", {31'd0, stall}, 32'd0);
      tick();
      chk("post-rst add", alu_result_out, 32'd5);
      chk("post-rst valid", {31'd0, valid_out}, 32'd1);
      read_hilo("post-rst", 32'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
